dmem_arbiter: RTL and testbench

Two-requester arbiter for the 8-bit data memory. It sits between `Processor_core`'s data port, a second burst requester (loader/DMA) and `data_memory`. The core has priority by default. The external requester is granted whole bursts when the core is idle, or after a bounded starvation wait. During a burst the core is stalled, and after every burst the core gets one guaranteed slot.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data memory arbiter: core priority, ext bursts, starvation bound
// Core owns the memory combinationally outside bursts; the external requester gets whole bursts.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [LEN_W-1:0]  ext_len,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic              ext_beat,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_done,

    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int SC_W = (STARVE > 1) ? $clog2(STARVE + 1) : 1;
    localparam logic [SC_W-1:0] STARVE_LAST = SC_W'(STARVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_SLOT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              ack_q, ack_d;
    logic [SC_W-1:0]   starve_q, starve_d;

    logic core_busy;
    logic in_burst;
    logic grant;

    always_comb begin
        core_busy = core_rd | core_wr;
        in_burst  = (state_q == ST_BURST);
        grant     = (state_q == ST_IDLE) && ext_req &&
                    (!core_busy || (starve_q == STARVE_LAST));

        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        ack_d    = 1'b0;
        starve_d = starve_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d  = ST_BURST;
                    addr_d   = ext_addr;
                    cnt_d    = ext_len;
                    we_d     = ext_we;
                    ack_d    = 1'b1;
                    starve_d = '0;
                end else if (ext_req) begin
                    if (starve_q != STARVE_LAST)
                        starve_d = starve_q + SC_W'(1);
                end else begin
                    starve_d = '0;
                end
            end
            ST_BURST: begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == '0)
                    state_d = ST_SLOT;
            end
            // The guaranteed core slot: no grant evaluation, starvation count frozen.
            ST_SLOT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            ack_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            starve_q <= starve_d;
        end
    end

    // Memory strobes are gated by rst so nothing is written or read while held in reset.
    always_comb begin
        if (in_burst) begin
            mem_access_addr = addr_q;
            mem_write_data  = ext_wdata;
            mem_write_en    = we_q & rst;
            mem_read        = ~we_q & rst;
            core_stall      = core_busy;
        end else begin
            mem_access_addr = core_addr;
            mem_write_data  = core_wdata;
            mem_write_en    = core_wr & rst;
            mem_read        = core_rd & rst;
            core_stall      = 1'b0;
        end
    end

    assign core_rdata = mem_read_data;
    assign ext_rdata  = mem_read_data;
    assign ext_ack    = ack_q;
    assign ext_beat   = in_burst;
    assign ext_done   = in_burst && (cnt_q == '0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with memory model and random scoreboard
module tb_dmem_arbiter;

    localparam int STARVE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       core_rd = 1'b0, core_wr = 1'b0;
    logic [7:0] core_addr = '0, core_wdata = '0, core_rdata;
    logic       core_stall;
    logic       ext_req = 1'b0, ext_we = 1'b0;
    logic [7:0] ext_addr = '0;
    logic [3:0] ext_len = '0;
    logic [7:0] ext_wdata = '0, ext_rdata;
    logic       ext_ack, ext_beat, ext_done;
    logic [7:0] mem_access_addr, mem_write_data, mem_read_data;
    logic       mem_write_en, mem_read;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       load_en = 1'b0;
    logic [7:0] load_addr = '0, load_data = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_access_addr];

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
    end

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
        .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_beat(ext_beat),
        .ext_rdata(ext_rdata), .ext_done(ext_done),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    // Loads random contents while the arbiter is held in reset; ref_mem mirrors them.
    task automatic load_mem();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            load_en   = 1'b1;
            load_addr = 8'(i);
            load_data = 8'($urandom);
            ref_mem[i] = load_data;
        end
        cyc();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        core_wr = 1'b1; core_addr = 8'h33; core_wdata = 8'hEE;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h00; ext_len = 4'd0;
        cyc(); #1;
        total_cnt++;
        if ({mem_write_en, mem_read, core_stall, ext_ack, ext_beat, ext_done} !== 6'b0)
            $display("FAIL reset_outputs got %b exp 000000",
                     {mem_write_en, mem_read, core_stall, ext_ack, ext_beat, ext_done});
        else pass_cnt++;
        rst = 1'b1; #1;
        total_cnt++;
        if ({ext_ack, ext_beat, core_stall, mem_write_en} !== 4'b0001)
            $display("FAIL release_idle got %b exp 0001", {ext_ack, ext_beat, core_stall, mem_write_en});
        else pass_cnt++;
        core_wr = 1'b0;
        cyc(); #1;
        total_cnt++;
        if ({ext_ack, ext_beat, ext_done} !== 3'b111)
            $display("FAIL release_first_grant got %b exp 111", {ext_ack, ext_beat, ext_done});
        else pass_cnt++;
        ext_req = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_core_only();
        cyc(); core_wr = 1'b1; core_addr = 8'h10; core_wdata = 8'h5A; #1;
        total_cnt++;
        if ({core_stall, mem_write_en, mem_access_addr} !== {1'b0, 1'b1, 8'h10})
            $display("FAIL core_write got %b/%b/%h exp 0/1/10", core_stall, mem_write_en, mem_access_addr);
        else pass_cnt++;
        cyc(); core_wr = 1'b0; core_rd = 1'b1; #1;
        total_cnt++;
        if ({core_stall, mem_read, core_rdata} !== {1'b0, 1'b1, 8'h5A})
            $display("FAIL core_read got %b/%b/%h exp 0/1/5a", core_stall, mem_read, core_rdata);
        else pass_cnt++;
        cyc(); core_rd = 1'b0;
    endtask

    task automatic test_ext_burst();
        logic [7:0] d [4];
        logic [7:0] a;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        for (int pass = 0; pass < 2; pass++) begin
            cyc(); ext_req = 1'b1; ext_we = (pass == 0); ext_addr = 8'hFE; ext_len = 4'd3; #1;
            total_cnt++;
            if (ext_beat !== 1'b0) $display("FAIL burst_pre_grant got %b exp 0", ext_beat);
            else pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                cyc(); ext_req = 1'b0; ext_wdata = d[i]; a = 8'hFE + 8'(i); #1;
                total_cnt++;
                if ({ext_ack, ext_beat, ext_done, mem_write_en, mem_read, mem_access_addr} !==
                    {(i == 0), 1'b1, (i == 3), (pass == 0), (pass == 1), a})
                    $display("FAIL burst_beat%0d got %b/%b/%b/%b/%b/%h exp ack=%0d done=%0d addr=%h",
                             i, ext_ack, ext_beat, ext_done, mem_write_en, mem_read, mem_access_addr,
                             i == 0, i == 3, a);
                else pass_cnt++;
                if (pass == 1) begin
                    total_cnt++;
                    if (ext_rdata !== d[i]) $display("FAIL burst_rdata%0d got %h exp %h", i, ext_rdata, d[i]);
                    else pass_cnt++;
                end
            end
            cyc(); #1;
            total_cnt++;
            if ({ext_ack, ext_beat, ext_done} !== 3'b0)
                $display("FAIL burst_slot got %b exp 000", {ext_ack, ext_beat, ext_done});
            else pass_cnt++;
            if (pass == 0) begin
                for (int i = 0; i < 4; i++) begin
                    a = 8'hFE + 8'(i);
                    total_cnt++;
                    if (mem[a] !== d[i]) $display("FAIL burst_mem_%h got %h exp %h", a, mem[a], d[i]);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_starvation();
        cyc();
        core_rd = 1'b1; core_addr = 8'h10;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h40; ext_len = 4'd1; ext_wdata = 8'h77;
        for (int k = 0; k < STARVE; k++) begin
            if (k > 0) cyc();
            #1;
            total_cnt++;
            if ({ext_beat, core_stall} !== 2'b00)
                $display("FAIL starve_refused%0d got %b exp 00", k, {ext_beat, core_stall});
            else pass_cnt++;
        end
        for (int b = 0; b < 2; b++) begin
            cyc(); ext_req = 1'b0; #1;
            total_cnt++;
            if ({ext_ack, ext_beat, ext_done, core_stall} !== {(b == 0), 1'b1, (b == 1), 1'b1})
                $display("FAIL starve_beat%0d got %b", b, {ext_ack, ext_beat, ext_done, core_stall});
            else pass_cnt++;
        end
        cyc(); #1;
        total_cnt++;
        if ({core_stall, ext_beat, mem_read, core_rdata} !== {1'b0, 1'b0, 1'b1, 8'h5A})
            $display("FAIL starve_slot_read got %b/%b/%b/%h exp 0/0/1/5a",
                     core_stall, ext_beat, mem_read, core_rdata);
        else pass_cnt++;
        core_rd = 1'b0;
        total_cnt++;
        if ({mem[8'h40], mem[8'h41]} !== 16'h7777)
            $display("FAIL starve_mem got %h%h exp 7777", mem[8'h40], mem[8'h41]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        cyc(); ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h80; ext_len = 4'd7; #1;
        for (int i = 0; i < 2; i++) begin
            cyc(); ext_req = 1'b0; ext_wdata = 8'hA0 + 8'(i); #1;
            total_cnt++;
            if (ext_beat !== 1'b1) $display("FAIL abort_beat%0d got %b exp 1", i, ext_beat);
            else pass_cnt++;
        end
        cyc(); ext_wdata = 8'hA2; core_wr = 1'b1; core_addr = 8'h90; core_wdata = 8'h99; rst = 1'b0; #1;
        total_cnt++;
        if ({mem_write_en, mem_read, core_stall, ext_ack, ext_beat, ext_done} !== 6'b0)
            $display("FAIL abort_outputs got %b exp 000000",
                     {mem_write_en, mem_read, core_stall, ext_ack, ext_beat, ext_done});
        else pass_cnt++;
        cyc(); core_wr = 1'b0; rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++;
            if ({ext_beat, ext_done} !== 2'b00) $display("FAIL abort_resume%0d got %b exp 00", k, {ext_beat, ext_done});
            else pass_cnt++;
            cyc();
        end
        total_cnt++;
        if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== {8'hA0, 8'hA1, ref_mem[8'h82]})
            $display("FAIL abort_mem got %h %h %h exp a0 a1 %h", mem[8'h80], mem[8'h81], mem[8'h82], ref_mem[8'h82]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cyc(); ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'hC0; ext_len = 4'd0; ext_wdata = 8'hC1; #1;
        cyc(); #1;
        total_cnt++;
        if ({ext_ack, ext_beat, ext_done} !== 3'b111) $display("FAIL b2b_first got %b exp 111", {ext_ack, ext_beat, ext_done});
        else pass_cnt++;
        cyc(); core_wr = 1'b1; core_addr = 8'h30; core_wdata = 8'h3C; #1;
        total_cnt++;
        if ({ext_ack, ext_beat, core_stall, mem_write_en} !== 4'b0001)
            $display("FAIL b2b_slot got %b exp 0001", {ext_ack, ext_beat, core_stall, mem_write_en});
        else pass_cnt++;
        cyc(); core_wr = 1'b0; #1;
        total_cnt++;
        if ({ext_ack, ext_beat} !== 2'b00) $display("FAIL b2b_idle got %b exp 00", {ext_ack, ext_beat});
        else pass_cnt++;
        cyc(); ext_wdata = 8'hC2; #1;
        total_cnt++;
        if ({ext_ack, ext_beat, ext_done} !== 3'b111) $display("FAIL b2b_second got %b exp 111", {ext_ack, ext_beat, ext_done});
        else pass_cnt++;
        ext_req = 1'b0;
        cyc(); cyc(); #1;
        total_cnt++;
        if ({mem[8'h30], mem[8'hC0]} !== {8'h3C, 8'hC2})
            $display("FAIL b2b_mem got %h %h exp 3c c2", mem[8'h30], mem[8'hC0]);
        else pass_cnt++;
    endtask

    // Scoreboard: expected beats, addresses, data and grant timing follow from the arbitration rules.
    task automatic test_random();
        int beats_left = 0, beat_idx = 0, refused = 0, r;
        bit pend = 0, slot_now = 0, slot_next = 0, grant_prev = 0, hold_core = 0, busy;
        logic [7:0] b_addr = '0, ea;
        logic [3:0] b_len = '0;
        logic b_we = 1'b0;
        core_rd = 1'b0; core_wr = 1'b0; ext_req = 1'b0;
        load_mem();
        rst = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (grant_prev) begin beats_left = int'(b_len) + 1; beat_idx = 0; end
            if (!hold_core) begin
                r = $urandom_range(0, 9);
                core_rd = (r < 4); core_wr = (r >= 4 && r < 7);
                core_addr = 8'($urandom); core_wdata = 8'($urandom);
            end
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1; ext_we = 1'($urandom); ext_addr = 8'($urandom); ext_len = 4'($urandom);
            end
            ext_req = pend; ext_wdata = 8'($urandom);
            #1;
            busy = core_rd | core_wr;
            grant_prev = 0;
            if (beats_left > 0) begin
                ea = b_addr + 8'(beat_idx);
                total_cnt++;
                if ({ext_beat, ext_ack, ext_done, core_stall, mem_access_addr} !==
                    {1'b1, (beat_idx == 0), (beats_left == 1), busy, ea})
                    $display("FAIL rnd_beat n=%0d got %b%b%b%b/%h exp 1%0d%0d%0d/%h", n, ext_beat, ext_ack,
                             ext_done, core_stall, mem_access_addr, beat_idx == 0, beats_left == 1, busy, ea);
                else pass_cnt++;
                if (b_we) ref_mem[ea] = ext_wdata;
                else begin
                    total_cnt++;
                    if (ext_rdata !== ref_mem[ea]) $display("FAIL rnd_ext_rdata n=%0d got %h exp %h", n, ext_rdata, ref_mem[ea]);
                    else pass_cnt++;
                end
                if (beat_idx == 0) pend = 0;
                beat_idx++; beats_left--;
                slot_next = (beats_left == 0);
                hold_core = busy;
            end else begin
                total_cnt++;
                if ({ext_beat, ext_ack, ext_done, core_stall} !== 4'b0)
                    $display("FAIL rnd_core_phase n=%0d got %b exp 0000", n, {ext_beat, ext_ack, ext_done, core_stall});
                else pass_cnt++;
                if (core_wr) ref_mem[core_addr] = core_wdata;
                if (core_rd) begin
                    total_cnt++;
                    if (core_rdata !== ref_mem[core_addr]) $display("FAIL rnd_core_rdata n=%0d got %h exp %h", n, core_rdata, ref_mem[core_addr]);
                    else pass_cnt++;
                end
                hold_core = 0;
                if (!slot_now) begin
                    if (ext_req) begin
                        if (!busy || refused == STARVE - 1) begin
                            grant_prev = 1; refused = 0;
                            b_addr = ext_addr; b_we = ext_we; b_len = ext_len;
                        end else refused++;
                    end else refused = 0;
                end
                slot_next = 0;
            end
            slot_now = slot_next;
        end
        cyc(); core_rd = 1'b0; core_wr = 1'b0; ext_req = 1'b0;
    endtask

    initial begin
        load_mem();
        test_reset();
        test_core_only();
        test_ext_burst();
        test_starvation();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
